// File: rtl/countdown_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_ctrl_pkg
// Description : Shared types and constants for the M:SS countdown controller.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MAX_SEC_TENS = 4'd5;
    localparam bcd_t MAX_DIGIT    = 4'd9;
    localparam int   DIGITS       = 3;
    localparam int   CNT_W        = $clog2(DIGITS + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DIGIT_CNT = cnt_t'(DIGITS);

    function automatic logic is_bcd(input bcd_t d);
        return d <= MAX_DIGIT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Modulo-DIV counter with run/hold/clear; wrap marks the last count.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic clrn,
    input  logic run,
    input  logic hold,
    input  logic clear,
    output logic wrap
);

    localparam int             W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]   c_last = W'(DIV - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run && !hold) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign wrap = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : countdown_ctrl
// Description : Keypad preset entry, load/run/pause sequencing and alarm for an
//               M:SS countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int ALARM_TICKS = 5
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        start,
    input  logic        stop,
    input  logic        clear_key,
    input  logic        zero,
    output logic [11:0] data,
    output logic        loadn,
    output logic        timer_clrn,
    output logic        enable,
    output logic        running,
    output logic        alarm,
    output logic        entry_err
);

    state_t r_state, w_state_next;
    bcd_t   r_mins, r_tens, r_ones;
    bcd_t   w_mins_next, w_tens_next, w_ones_next;
    cnt_t   r_count, w_count_next;
    logic   w_err_ev, w_clr_ev;
    logic   w_presc_wrap, w_alarm_wrap, w_alarm_done;
    logic   w_key_ok, w_all_zero;
    logic   r_loadn, r_timer_clrn, r_running, r_alarm, r_entry_err;

    assign w_key_ok   = key_valid && is_bcd(key_digit);
    assign w_all_zero = (r_mins == '0) && (r_tens == '0) && (r_ones == '0);

    // Stop is ignored on the same cycle zero arrives: reaching 0:00 wins.
    tick_gen #(.DIV(TICK_DIV)) u_presc (
        .clock (clock),
        .clrn  (clrn),
        .run   ((r_state == ST_RUN) || (r_state == ST_DONE)),
        .hold  ((r_state == ST_RUN) && stop && !zero),
        .clear (r_state == ST_LOAD),
        .wrap  (w_presc_wrap)
    );

    // Counts prescaler wraps while the alarm is sounding.
    tick_gen #(.DIV(ALARM_TICKS)) u_alarm (
        .clock (clock),
        .clrn  (clrn),
        .run   ((r_state == ST_DONE) && w_presc_wrap),
        .hold  (1'b0),
        .clear (r_state != ST_DONE),
        .wrap  (w_alarm_wrap)
    );

    assign w_alarm_done = (r_state == ST_DONE) && w_presc_wrap && w_alarm_wrap;

    always_comb begin
        w_state_next = r_state;
        w_mins_next  = r_mins;
        w_tens_next  = r_tens;
        w_ones_next  = r_ones;
        w_count_next = r_count;
        w_err_ev     = 1'b0;
        w_clr_ev     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_key_ok) begin
                    w_mins_next  = '0;
                    w_tens_next  = '0;
                    w_ones_next  = key_digit;
                    w_count_next = cnt_t'(1);
                    w_state_next = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (clear_key) begin
                    w_mins_next  = '0;
                    w_tens_next  = '0;
                    w_ones_next  = '0;
                    w_count_next = '0;
                    w_state_next = ST_IDLE;
                end else if (stop) begin
                    w_state_next = ST_ENTRY;
                end else if (start) begin
                    if (r_tens > MAX_SEC_TENS) begin
                        w_err_ev     = 1'b1;
                        w_mins_next  = '0;
                        w_tens_next  = '0;
                        w_ones_next  = '0;
                        w_count_next = '0;
                        w_state_next = ST_IDLE;
                    end else if (!w_all_zero) begin
                        w_state_next = ST_LOAD;
                    end
                end else if (w_key_ok && (r_count < DIGIT_CNT)) begin
                    w_mins_next  = r_tens;
                    w_tens_next  = r_ones;
                    w_ones_next  = key_digit;
                    w_count_next = r_count + 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (zero) begin
                    w_state_next = ST_DONE;
                end else if (stop) begin
                    w_state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (clear_key) begin
                    w_clr_ev     = 1'b1;
                    w_mins_next  = '0;
                    w_tens_next  = '0;
                    w_ones_next  = '0;
                    w_count_next = '0;
                    w_state_next = ST_IDLE;
                end else if (stop) begin
                    w_state_next = ST_PAUSE;
                end else if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (clear_key || key_valid || w_alarm_done) begin
                    w_clr_ev     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_state      <= ST_IDLE;
            r_mins       <= '0;
            r_tens       <= '0;
            r_ones       <= '0;
            r_count      <= '0;
            r_loadn      <= 1'b1;
            r_timer_clrn <= 1'b0;
            r_running    <= 1'b0;
            r_alarm      <= 1'b0;
            r_entry_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_mins       <= w_mins_next;
            r_tens       <= w_tens_next;
            r_ones       <= w_ones_next;
            r_count      <= w_count_next;
            r_loadn      <= (w_state_next != ST_LOAD);
            r_timer_clrn <= !w_clr_ev;
            r_running    <= (w_state_next == ST_RUN);
            r_alarm      <= (w_state_next == ST_DONE);
            r_entry_err  <= w_err_ev;
        end
    end

    assign data       = {r_mins, r_tens, r_ones};
    assign loadn      = r_loadn;
    assign timer_clrn = r_timer_clrn;
    assign running    = r_running;
    assign alarm      = r_alarm;
    assign entry_err  = r_entry_err;
    assign enable     = (r_state == ST_RUN) && w_presc_wrap && !zero;

endmodule
`default_nettype wire

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Front-end controller that drives a three-digit M:SS countdown timer's load/clear/enable interface and consumes its zero flag.
- Collects keypad digits into an M:SS preset, validates it, and loads the timer.
- Generates the 1 Hz count-enable from the system clock and sequences run/pause/clear.
- Raises an alarm when the timer reaches 0:00. Sits between the keypad decoder and the timer datapath.

Parameters:
- TICK_DIV, 50_000_000, clock cycles per count-enable pulse (must be ≥2).
- ALARM_TICKS, 5, number of ticks alarm stays high in DONE.

Ports:
- clock  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe, key_digit valid.
- key_digit  in  4  BCD digit from keypad.
- start  in  1  one-cycle start/resume strobe.
- stop  in  1  one-cycle pause strobe.
- clear_key  in  1  one-cycle clear strobe.
- zero  in  1  timer reports 0:00.
- data  out  12  preset to timer {mins[11:8], sec_tens[7:4], sec_ones[3:0]}.
- loadn  out  1  active-low synchronous load strobe to timer.
- timer_clrn  out  1  active-low clear to timer.
- enable  out  1  one-cycle count-down enable to timer.
- running  out  1  high in RUN.
- alarm  out  1  high in DONE.
- entry_err  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset (clrn low, async): state IDLE; digit register 0; data=0; loadn=1; timer_clrn=0; enable=0; running=0; alarm=0; entry_err=0; prescaler=0. timer_clrn goes to 1 on the first clock after clrn is released.
- States: IDLE, ENTRY, LOAD, RUN, PAUSE, DONE.
- IDLE:
  - key_valid with key_digit≤9 → digit register = {0,0,key_digit}, go to ENTRY.
  - key_digit>9 is ignored.
- ENTRY:
  - key_valid with digit≤9 shifts left: mins←tens, tens←ones, ones←key_digit. Only while fewer than 3 digits have been entered; later keys are ignored.
  - start:
    - sec_tens>5 → entry_err pulse, digit register cleared, go to IDLE.
    - All digits zero → start ignored.
    - Otherwise go to LOAD.
  - clear_key → digit register cleared, go to IDLE.
- LOAD: exactly one cycle.
  - loadn=0, with data = digit register held stable the same cycle.
  - Prescaler reset to 0. Next state RUN.
- RUN:
  - running=1.
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - enable = (prescaler==TICK_DIV-1) & ~zero. This output is combinational from the registered prescaler and the zero input.
  - zero==1 → next state DONE, no enable that cycle.
  - stop → PAUSE; prescaler holds its value.
  - start and key_valid are ignored.
- PAUSE:
  - enable=0; prescaler holds.
  - start → RUN, resuming from the held prescaler value.
  - clear_key → timer_clrn=0 for one cycle, digit register cleared, go to IDLE.
- DONE:
  - alarm=1; prescaler keeps running.
  - Go to IDLE after ALARM_TICKS wraps, or immediately on clear_key or key_valid. The key is consumed and not entered.
  - On exit, timer_clrn=0 for one cycle.
- Simultaneous strobes:
  - clear_key beats stop, and stop beats start.
  - In ENTRY, key_valid together with start: the key is ignored and start is evaluated on the old register.
- Registered outputs: loadn, timer_clrn, running, alarm, entry_err, data. Only enable is combinational.

Decomposition:
- Shared package holds:
  - State enum (IDLE..DONE, 3-bit encoding).
  - Constants MAX_SEC_TENS=5, MAX_DIGIT=9, DIGITS=3.
  - BCD digit typedef (4-bit).
- Sub-module tick_gen: the prescaler with inputs run/hold/clear and output wrap. It is reused for the alarm timeout.

Test Plan (TICK_DIV=4, ALARM_TICKS=2):
1. Keys 1,3,0 then start → data=0x130, loadn low exactly one cycle, then enable pulses every 4th cycle, running=1.
2. Keys 1,7,5 then start → entry_err pulses once, no loadn, state returns to IDLE (running=0).
3. Keys 1,2,3,4 then start → data=0x123; the 4th key is ignored.
4. RUN, then stop, hold 10 cycles, then start → no enable during pause. The first enable after resume comes 4 minus (prescaler at stop) cycles later. clear_key in PAUSE → timer_clrn low one cycle, then IDLE.
5. Drive zero=1 in RUN → enable stays 0, alarm rises next cycle, falls after 8 cycles, and timer_clrn pulses low once on exit.
6. Assert clrn low mid-RUN → all outputs reach reset values asynchronously. After release, timer_clrn=1 and the controller is in IDLE with data=0.
